sigmoid_seq: RTL
================

Name: sigmoid_seq

Overview:
- Feeder/collector stage wrapped around one sigmoid activation unit in the LSTM_NET_16K gate datapath.
- Accepts gate pre-activations on a valid/ready stream and buffers them in a small FIFO.
- Issues them to the activation unit one at a time using its level-style IN_valid protocol, and waits for the single-cycle OUT_valid pulse.
- Returns results in order on a valid/ready stream. A timeout counter guards against a lost OUT_valid.

Parameters:
- xDW, 24, pre-activation width; signed, 14 fractional bits by convention.
- oDW, 24, activation result width.
- DEPTH, 4, input FIFO entries; power of 2, ≥2.
- TO_W, 10, timeout counter width; timeout at 2^TO_W-1 cycles.
- GAP, 2, minimum cycles act_IN_valid is held low between requests; ≥1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-low reset.
- s_valid, input, 1, upstream data valid.
- s_ready, output, 1, FIFO not full.
- s_data, input, xDW, signed pre-activation.
- act_IN_valid, output, 1, to activation unit IN_valid.
- act_x, output, xDW, to activation unit x_IN.
- act_OUT, input, oDW, from activation unit OUT.
- act_OUT_valid, input, 1, one-cycle result pulse from activation unit.
- m_valid, output, 1, result valid.
- m_ready, input, 1, downstream accept.
- m_data, output, oDW, result.
- m_err, output, 1, qualifies m_data; 1 = timed out, m_data=0.
- busy, output, 1, FSM not in IDLE or FIFO non-empty.
- level, output, clog2(DEPTH)+1, FIFO occupancy.

Behaviour:
- Reset values (async, rst=0): all outputs 0, FSM=IDLE, FIFO empty, counters 0. At reset, s_ready becomes 1 on the first clk after rst deasserts.
- FIFO:
  - Push when s_valid & s_ready.
  - s_ready = (level != DEPTH); registered-occupancy based, so there is no push while full, even if a pop happens the same cycle.
  - Pop happens only on the WAIT→RESP transition.
  - Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP.
  - IDLE: if FIFO non-empty → ISSUE.
  - ISSUE (1 cycle): latch FIFO head into act_x; set act_IN_valid=1; → WAIT.
  - WAIT:
    - act_IN_valid held 1 and act_x held stable; timeout counter increments each cycle.
    - On act_OUT_valid=1: m_data<=act_OUT, m_err<=0, m_valid<=1, pop, act_IN_valid<=0, → RESP.
    - Else if counter reaches 2^TO_W-1: m_data<=0, m_err<=1, m_valid<=1, pop, act_IN_valid<=0, → RESP.
    - act_OUT_valid takes priority when it coincides with the timeout cycle.
  - RESP:
    - m_valid and m_data stay stable until m_ready.
    - The gap counter runs concurrently from the cycle act_IN_valid fell.
    - On m_ready: m_valid<=0; if gap counter ≥ GAP → IDLE, else → GAP.
  - GAP: wait until act_IN_valid has been low ≥ GAP cycles → IDLE.
- Ordering: strictly one request in flight; results are returned in input order.
- act_OUT_valid outside WAIT is ignored. No state change and no error occur.
- act_x holds its last value when not in ISSUE/WAIT. It is 0 after reset.
- Minimum latency, s_data accepted to m_valid: 3 + Lact cycles, where Lact is the cycles from act_IN_valid rise to the act_OUT_valid pulse.
- Mid-operation reset: everything is cleared asynchronously. act_IN_valid drops to 0 immediately and any in-flight request is discarded. A later stray act_OUT_valid is ignored (FSM is in IDLE).

Test Plan:
- Single item, stub activation with Lact=5 returning x+1: s_data=0x000100 → act_IN_valid high for exactly 6 cycles; m_valid with m_data=0x000101, m_err=0, 8 cycles after push.
- Burst of 6 items (0x10..0x15) with m_ready=1, DEPTH=4 → s_ready deasserts after 4 accepted (plus 1 once the first pop occurs); outputs 0x11..0x16 in order; act_IN_valid low ≥2 cycles between each request.
- Backpressure: m_ready=0 for 20 cycles after the first result → m_data stable for 20 cycles; no new act_IN_valid rise until after m_ready=1 is accepted; level climbs to 4 and holds.
- Timeout, TO_W=4, stub never pulses → m_valid at 15 WAIT cycles with m_data=0, m_err=1; next item then issues normally with m_err=0.
- Stray act_OUT_valid pulse while in IDLE and while in RESP → no output change, level unchanged.
- rst=0 asserted in WAIT → act_IN_valid, m_valid, s_ready, level all 0 with no clock edge; after release, the stub's late pulse is ignored and a fresh push completes correctly.

Source files
------------

// File: rtl/sigmoid_seq.sv
// Feeder/collector around one sigmoid activation unit: buffers pre-activations in a
// small FIFO, issues them one at a time, and returns results (or timeouts) in order.
module sigmoid_seq #(
  parameter int xDW   = 24,
  parameter int oDW   = 24,
  parameter int DEPTH = 4,
  parameter int TO_W  = 10,
  parameter int GAP   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [xDW-1:0]             s_data,
  output logic                       act_IN_valid,
  output logic [xDW-1:0]             act_x,
  input  logic [oDW-1:0]             act_OUT,
  input  logic                       act_OUT_valid,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [oDW-1:0]             m_data,
  output logic                       m_err,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP + 1) + 1;
  localparam logic [LW-1:0]   FULL    = LW'(DEPTH);
  localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);
  localparam logic [GW-1:0]   GAP_SAT = GW'(GAP);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [xDW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]   wrPtr_q, rdPtr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            sReady_q;
  logic            actValid_q, actValid_d;
  logic [xDW-1:0]  actX_q, actX_d;
  logic            mValid_q, mValid_d;
  logic [oDW-1:0]  mData_q, mData_d;
  logic            mErr_q, mErr_d;
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic [GW-1:0]   gapCnt_q, gapCnt_d;
  logic            push, pop, gapDone;

  assign push    = s_valid & sReady_q;
  assign level_d = level_q + LW'(push) - LW'(pop);
  // gapCnt_q lags by one edge, so the cycle in progress is counted here
  assign gapDone = (int'(gapCnt_q) + 1) >= GAP;

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      sReady_q   <= 1'b0;
      actValid_q <= 1'b0;
      actX_q     <= '0;
      mValid_q   <= 1'b0;
      mData_q    <= '0;
      mErr_q     <= 1'b0;
      toCnt_q    <= '0;
      gapCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      level_q    <= level_d;
      sReady_q   <= (level_d != FULL);
      actValid_q <= actValid_d;
      actX_q     <= actX_d;
      mValid_q   <= mValid_d;
      mData_q    <= mData_d;
      mErr_q     <= mErr_d;
      toCnt_q    <= toCnt_d;
      gapCnt_q   <= gapCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    actValid_d = actValid_q;
    actX_d     = actX_q;
    mValid_d   = mValid_q;
    mData_d    = mData_q;
    mErr_d     = mErr_q;
    toCnt_d    = toCnt_q;
    pop        = 1'b0;
    if (actValid_q)
      gapCnt_d = '0;
    else if (gapCnt_q == GAP_SAT)
      gapCnt_d = gapCnt_q;
    else
      gapCnt_d = gapCnt_q + GW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (level_q != '0) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        actX_d     = mem_q[rdPtr_q];
        actValid_d = 1'b1;
        toCnt_d    = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        toCnt_d = toCnt_q + TO_W'(1);
        // A real result wins over a timeout landing on the same cycle
        if (act_OUT_valid) begin
          mData_d    = act_OUT;
          mErr_d     = 1'b0;
          mValid_d   = 1'b1;
          pop        = 1'b1;
          actValid_d = 1'b0;
          state_d    = S_RESP;
        end else if (toCnt_q == TO_LAST) begin
          mData_d    = '0;
          mErr_d     = 1'b1;
          mValid_d   = 1'b1;
          pop        = 1'b1;
          actValid_d = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (m_ready) begin
          mValid_d = 1'b0;
          state_d  = gapDone ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gapDone) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign s_ready      = sReady_q;
  assign act_IN_valid = actValid_q;
  assign act_x        = actX_q;
  assign m_valid      = mValid_q;
  assign m_data       = mData_q;
  assign m_err        = mErr_q;
  assign level        = level_q;
  assign busy         = (state_q != S_IDLE) || (level_q != '0);

endmodule
